// File: rtl/chunk_serial_adder.sv
// Area-lean adder/subtractor that processes CHUNK bits per clock, carrying between chunks in a
// register. Results are presented for one cycle under a start/busy/done handshake.
module chunk_serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int unsigned N      = WIDTH / CHUNK;
    localparam int unsigned KW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLast = KW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_d, sum_q;
    logic [KW-1:0]    k_q;
    logic             c_q, busy_q, done_q, cout_q, ovf_q;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             res_ovf;

    always_comb begin
        a_chunk   = a_q[k_q*CHUNK +: CHUNK];
        b_chunk   = b_q[k_q*CHUNK +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_q};
        res_d     = res_q;
        res_d[k_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        // Signs of the prepared operands, so subtract overflow falls out of the same rule.
        res_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            k_q     <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i ^ {WIDTH{sub_i}};
                        c_q     <= cin_i ^ sub_i;
                        k_q     <= '0;
                        res_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    res_q <= res_d;
                    c_q   <= chunk_sum[CHUNK];
                    k_q   <= k_q + 1'b1;
                    if (k_q == KLast) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= res_d;
                        cout_q  <= chunk_sum[CHUNK];
                        ovf_q   <= res_ovf;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Bench for chunk_serial_adder: four parameterisations share one stimulus bus and are checked
// against an arithmetic reference model, plus directed handshake and reset sequences.
module tb_chunk_serial_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a16, b16;
    logic        cin, sub;

    logic        busy_w[4];
    logic        done_w[4];
    logic        cout_w[4];
    logic        ovf_w[4];
    logic [15:0] sum_w[4];
    logic [7:0]  s0, s1, s2;
    logic [15:0] s3;

    logic [15:0] got_s[4];
    logic        got_c[4];
    logic        got_o[4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    vec_t tbl[9];

    chunk_serial_adder #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a16[7:0]), .b_i(b16[7:0]),
        .cin_i(cin), .sub_i(sub), .busy_o(busy_w[0]), .done_o(done_w[0]), .sum_o(s0),
        .cout_o(cout_w[0]), .ovf_o(ovf_w[0])
    );
    chunk_serial_adder #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a16[7:0]), .b_i(b16[7:0]),
        .cin_i(cin), .sub_i(sub), .busy_o(busy_w[1]), .done_o(done_w[1]), .sum_o(s1),
        .cout_o(cout_w[1]), .ovf_o(ovf_w[1])
    );
    chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a16[7:0]), .b_i(b16[7:0]),
        .cin_i(cin), .sub_i(sub), .busy_o(busy_w[2]), .done_o(done_w[2]), .sum_o(s2),
        .cout_o(cout_w[2]), .ovf_o(ovf_w[2])
    );
    chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a16), .b_i(b16),
        .cin_i(cin), .sub_i(sub), .busy_o(busy_w[3]), .done_o(done_w[3]), .sum_o(s3),
        .cout_o(cout_w[3]), .ovf_o(ovf_w[3])
    );

    always_comb begin
        sum_w[0] = {8'h00, s0};
        sum_w[1] = {8'h00, s1};
        sum_w[2] = {8'h00, s2};
        sum_w[3] = s3;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int n_of(input int i);
        case (i)
            0: return 4;
            1: return 8;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int w_of(input int i);
        return (i == 3) ? 16 : 8;
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                  input logic ci, input logic sb, output logic [15:0] es,
                                  output logic ec, output logic eo);
        longint m, ua, ub, sa, sbv, full, r;
        m   = longint'(1) << w;
        ua  = longint'(av) & (m - 1);
        ub  = longint'(bv) & (m - 1);
        sa  = (ua >= m / 2) ? ua - m : ua;
        sbv = (ub >= m / 2) ? ub - m : ub;
        if (!sb) begin
            full = ua + ub + longint'(ci);
            ec   = (full >= m);
            r    = sa + sbv + longint'(ci);
        end else begin
            full = ua - ub - longint'(ci);
            ec   = (full >= 0);
            r    = sa - sbv - longint'(ci);
        end
        es = 16'(full & (m - 1));
        eo = (r >= m / 2) || (r < -(m / 2));
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    // One operation on all four instances; inputs are scrambled right after acceptance.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         input logic sb);
        logic [15:0] es;
        logic        ec, eo;
        @(negedge clk);
        a16 = av; b16 = bv; cin = ci; sub = sb; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a16 = ~av; b16 = ~bv; cin = ~ci; sub = ~sb;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                chk1($sformatf("busy%0d_c%0d", i, cyc), busy_w[i], cyc <= n_of(i));
                chk1($sformatf("done%0d_c%0d", i, cyc), done_w[i], cyc == n_of(i) + 1);
                if (cyc == n_of(i) + 1) begin
                    got_s[i] = sum_w[i];
                    got_c[i] = cout_w[i];
                    got_o[i] = ovf_w[i];
                    model(w_of(i), av, bv, ci, sb, es, ec, eo);
                    chk($sformatf("sum%0d", i), sum_w[i], es);
                    chk1($sformatf("cout%0d", i), cout_w[i], ec);
                    chk1($sformatf("ovf%0d", i), ovf_w[i], eo);
                end
            end
            if (cyc < 10) @(negedge clk);
        end
    endtask

    task automatic settle();
        start = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{a: 8'd15,  b: 8'd15, cin: 1'b0, sub: 1'b0, s: 8'd30,  c: 1'b0, o: 1'b0};
        tbl[1] = '{a: 8'd255, b: 8'd1,  cin: 1'b0, sub: 1'b0, s: 8'd0,   c: 1'b1, o: 1'b0};
        tbl[2] = '{a: 8'd10,  b: 8'd5,  cin: 1'b1, sub: 1'b0, s: 8'd16,  c: 1'b0, o: 1'b0};
        tbl[3] = '{a: 8'd10,  b: 8'd5,  cin: 1'b0, sub: 1'b1, s: 8'd5,   c: 1'b1, o: 1'b0};
        tbl[4] = '{a: 8'd5,   b: 8'd10, cin: 1'b0, sub: 1'b1, s: 8'd251, c: 1'b0, o: 1'b0};
        tbl[5] = '{a: 8'd165, b: 8'd90, cin: 1'b1, sub: 1'b1, s: 8'd74,  c: 1'b1, o: 1'b1};
        tbl[6] = '{a: 8'd127, b: 8'd1,  cin: 1'b0, sub: 1'b0, s: 8'd128, c: 1'b0, o: 1'b1};
        tbl[7] = '{a: 8'd128, b: 8'd1,  cin: 1'b0, sub: 1'b1, s: 8'd127, c: 1'b1, o: 1'b1};
        tbl[8] = '{a: 8'd165, b: 8'd90, cin: 1'b0, sub: 1'b0, s: 8'd255, c: 1'b0, o: 1'b0};

        rst = 1'b1; start = 1'b0; a16 = '0; b16 = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk1($sformatf("rst_busy%0d", i), busy_w[i], 1'b0);
            chk1($sformatf("rst_done%0d", i), done_w[i], 1'b0);
            chk($sformatf("rst_sum%0d", i), sum_w[i], 16'h0000);
            chk1($sformatf("rst_cout%0d", i), cout_w[i], 1'b0);
            chk1($sformatf("rst_ovf%0d", i), ovf_w[i], 1'b0);
        end
        rst = 1'b0;

        for (int t = 0; t < 9; t++) begin
            do_op({8'h00, tbl[t].a}, {8'h00, tbl[t].b}, tbl[t].cin, tbl[t].sub);
            chk($sformatf("tbl%0d_sum", t), got_s[0], {8'h00, tbl[t].s});
            chk1($sformatf("tbl%0d_cout", t), got_c[0], tbl[t].c);
            chk1($sformatf("tbl%0d_ovf", t), got_o[0], tbl[t].o);
        end

        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("w16_sum", got_s[3], 16'h0000);
        chk1("w16_cout", got_c[3], 1'b1);
        settle();

        // Start pulsed mid-run with new operands, then operands changed again: both ignored.
        @(negedge clk); a16 = 16'd15; b16 = 16'd15; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; a16 = 16'd1; b16 = 16'd1;
        @(negedge clk); start = 1'b0; a16 = 16'd200; b16 = 16'd77;
        @(negedge clk);
        chk1("ign_busy_c4", busy_w[0], 1'b1);
        chk1("ign_done_c4", done_w[0], 1'b0);
        @(negedge clk);
        chk1("ign_done_c5", done_w[0], 1'b1);
        chk("ign_sum", sum_w[0], 16'd30);
        @(negedge clk);
        chk1("ign_done_c6", done_w[0], 1'b0);
        settle();

        // Start held through DONE: next operation begins with no idle cycle.
        @(negedge clk); a16 = 16'd15; b16 = 16'd15; cin = 1'b0; sub = 1'b0; start = 1'b1;
        repeat (4) @(negedge clk);
        @(negedge clk);
        chk1("b2b_done1", done_w[0], 1'b1);
        chk("b2b_sum1", sum_w[0], 16'd30);
        a16 = 16'd127; b16 = 16'd1;
        @(negedge clk); start = 1'b0;
        chk1("b2b_busy", busy_w[0], 1'b1);
        chk1("b2b_done_low", done_w[0], 1'b0);
        chk("b2b_sum_hold", sum_w[0], 16'd30);
        repeat (3) @(negedge clk);
        chk1("b2b_done_c9", done_w[0], 1'b0);
        @(negedge clk);
        chk1("b2b_done2", done_w[0], 1'b1);
        chk("b2b_sum2", sum_w[0], 16'd128);
        chk1("b2b_ovf2", ovf_w[0], 1'b1);
        settle();

        // Reset sampled at E2 aborts the operation and clears the result registers.
        @(negedge clk); a16 = 16'd15; b16 = 16'd15; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk1("abort_busy", busy_w[0], 1'b0);
        chk("abort_sum", sum_w[0], 16'h0000);
        chk1("abort_cout", cout_w[0], 1'b0);
        chk1("abort_ovf", ovf_w[0], 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk1($sformatf("abort_done%0d", c), done_w[0], 1'b0);
            @(negedge clk);
        end
        do_op(16'd15, 16'd15, 1'b0, 1'b0);
        chk("after_abort_sum", got_s[0], 16'd30);

        repeat (200) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chunk_serial_adder.md
# chunk_serial_adder

Multi-cycle, parametrised successor to the single-cycle 8-bit ripple adder. Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register. Operation is under a start/busy/done handshake. It sits in the arithmetic datapath where area matters more than latency, and it also adds a subtract mode and signed-overflow detection.

## Interface
- WIDTH, 8: operand and result width; must be a multiple of CHUNK.
- CHUNK, 2: bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK is the number of compute cycles.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the FSM is in IDLE or DONE.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- cin  input  1  carry-in (add) or borrow-in (sub), captured on the accepting edge.
- sub  input  1  0 = a+b+cin, 1 = a−b−cin; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE; results are valid in that cycle.
- sum  output  WIDTH  result, unsigned modulo 2^WIDTH.
- cout  output  1  add: carry-out. Sub: NOT borrow (1 = no borrow).
- ovf  output  1  two's-complement signed overflow of the operation.

## Operation
- FSM states: IDLE, RUN, DONE.
- Operand preparation on accept:
  - Latch A = a.
  - Latch B = b XOR {WIDTH{sub}}.
  - Set carry register C = cin XOR sub.
  - Clear chunk counter k = 0.
  - Capture sub.
- RUN, each edge:
  - Compute {c, s} = A[k*CHUNK +: CHUNK] + B[k*CHUNK +: CHUNK] + C.
  - Write s into the result shift or slice register at chunk k, set C = c, then k++.
  - On the edge processing chunk N−1, go to DONE.
- ovf = (sign of A == sign of B) AND (sign of result ≠ sign of A), using the prepared A and B.
- On entry to DONE, write sum, cout (final C) and ovf to the output registers.
- The output registers hold their values until the next entry to DONE or reset; they do not change during RUN.
- Transitions:
  - IDLE → RUN on start.
  - RUN → RUN while k < N−1.
  - RUN → DONE after chunk N−1.
  - DONE → RUN if start, otherwise DONE → IDLE.
- Boundary conditions:
  - start while in RUN is ignored: no queueing and no effect on the operation in progress.
  - Changes to a, b, cin or sub after acceptance have no effect.
  - CHUNK == WIDTH (N = 1): one RUN cycle, then DONE.
  - Reset mid-operation aborts: no done pulse, and all outputs go to their reset values.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, internal registers 0.
- Accepting edge E0 (start high, state IDLE or DONE): busy = 1 from the cycle after E0.
- Edges E1..EN process chunks 0..N−1.
- After EN: busy = 0, done = 1, sum/cout/ovf valid.
- After EN+1: done = 0. If start was high at EN+1, this edge is the new E0.
- Latency from the accepting edge to done high is N+1 cycles.
- Back-to-back throughput is one result per N+1 cycles.
- rst has priority over start on the same edge.

## Test plan
WIDTH=8, CHUNK=2 (N=4) unless stated.
- Add: a=15, b=15, cin=0 → sum=30 (0x1E), cout=0, ovf=0. done high exactly in the cycle after E4; busy high in cycles 1–4 after E0.
- Carry chain across all chunks, first case: a=255, b=1, cin=0 → sum=0, cout=1, ovf=0.
- Carry chain, second case: a=10, b=5, cin=1 → sum=16, cout=0.
- Subtract: a=10, b=5, sub=1, cin=0 → sum=5, cout=1.
- Subtract with borrow-out: a=5, b=10, sub=1 → sum=251, cout=0.
- Subtract with borrow-in: a=165, b=90, sub=1, cin=1 → sum=74, cout=1.
- Overflow: a=127, b=1 add → sum=128, ovf=1. a=128, b=1 sub → sum=127, ovf=1. a=165, b=90 add → sum=255, ovf=0.
- Handshake:
  - Pulse start again at E2 with a=1, b=1: ignored; the original result is delivered.
  - Hold start high through DONE: a new operation starts at EN+1 with no idle cycle.
  - Change a/b during RUN: the result is unaffected.
- Reset mid-operation: assert rst at E2 of 15+15 → done never pulses. The cycle after reset shows busy=0, sum=0, cout=0, ovf=0, and a new start then completes normally.
- Parameter sweep:
  - CHUNK=1, WIDTH=8: 9-cycle latency.
  - CHUNK=8, WIDTH=8: 2-cycle latency.
  - WIDTH=16, CHUNK=4: 0xFFFF+0x0001 → sum=0, cout=1.
  - All three: 200 random vectors checked against a+b+cin and a−b−cin reference models.
